// File: rtl/alu32_stage.sv
// Registered, handshaked ALU stage: single-cycle logic/arithmetic ops plus
// bit-serial shifts, with one held result per operation until writeback takes it.
module alu32_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [1:0]       o_dbg_state
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] CNT_ZERO = '0;
   localparam logic [SW-1:0] CNT_ONE  = SW'(1);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_overflow;
   logic [WIDTH-1:0] r_acc;
   logic [SW-1:0]    r_cnt;
   logic [2:0]       r_op;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_slt;
   logic [SW-1:0]    w_shamt;
   logic             w_is_shift;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ovf;
   logic [WIDTH-1:0] w_acc_next;

   // Handshake: a transfer happens on any rising edge where valid && ready.
   // in_ready is high only in IDLE; out_valid is high only in DONE.
   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign result      = r_result;
   assign zero        = r_zero;
   assign overflow    = r_overflow;
   assign o_dbg_state = r_state;

   assign w_sum      = a + b;
   assign w_diff     = a - b;
   assign w_slt      = ($signed(a) < $signed(b));
   assign w_shamt    = b[SW-1:0];
   assign w_is_shift = (op == OP_SLL) || (op == OP_SRL);
   assign w_acc_next = (r_op == OP_SLL) ? (r_acc << 1) : (r_acc >> 1);

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (op)
         OP_AND: w_alu_res = a & b;
         OP_OR:  w_alu_res = a | b;
         OP_ADD: begin
            w_alu_res = w_sum;
            w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_diff;
            w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
         default: w_alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_op       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_op <= op;
                  if (w_is_shift) begin
                     if (w_shamt == CNT_ZERO) begin
                        r_result   <= a;
                        r_zero     <= (a == '0);
                        r_overflow <= 1'b0;
                        r_state    <= S_DONE;
                     end else begin
                        r_acc   <= a;
                        r_cnt   <= w_shamt;
                        r_state <= S_SHIFT;
                     end
                  end else begin
                     r_result   <= w_alu_res;
                     r_zero     <= (w_alu_res == '0);
                     r_overflow <= w_alu_ovf;
                     r_state    <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt - CNT_ONE;
               // Last bit position: publish the final shifted value directly.
               if (r_cnt == CNT_ONE) begin
                  r_result   <= w_acc_next;
                  r_zero     <= (w_acc_next == '0);
                  r_overflow <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu32_stage.sv
// Directed and random bench for alu32_stage with an expected-result queue
// filled on issue and drained when the stage presents its result.
module tb_alu32_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic [1:0]  o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [33:0] exp_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   alu32_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow), .o_dbg_state(o_dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: {overflow, zero, result}
   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic [2:0] mop);
      logic [31:0] r;
      logic        ov;
      r  = 32'h0;
      ov = 1'b0;
      case (mop)
         3'b000: r = ma & mb;
         3'b001: r = ma | mb;
         3'b010: begin
            r  = ma + mb;
            ov = (ma[31] == mb[31]) && (r[31] != ma[31]);
         end
         3'b110: begin
            r  = ma - mb;
            ov = (ma[31] != mb[31]) && (r[31] != ma[31]);
         end
         3'b111: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
         3'b100: r = ma << mb[4:0];
         3'b101: r = ma >> mb[4:0];
         default: r = 32'h0;
      endcase
      return {ov, (r == 32'h0), r};
   endfunction

   function automatic int latency(input logic [31:0] mb, input logic [2:0] mop);
      if ((mop == 3'b100 || mop == 3'b101) && mb[4:0] != 5'd0) return int'(mb[4:0]) + 1;
      return 1;
   endfunction

   // Drive one operand bundle at a falling edge; returns just after the accepting edge.
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("issue_in_ready", 32'(in_ready), 32'd1);
      a        = ia;
      b        = ib;
      op       = iop;
      in_valid = 1'b1;
      exp_q.push_back(model(ia, ib, iop));
      lat_q.push_back(latency(ib, iop));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
   endtask

   // Wait for the result, compare against the queue, optionally stall, then retire.
   task automatic collect(input int hold);
      int          edges;
      logic [33:0] e;
      int          l;
      edges = 1;
      while (!out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check("out_valid_seen", 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check("queue_nonempty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         l = lat_q.pop_front();
         check("latency", 32'(edges), 32'(l));
         check("result", result, e[31:0]);
         check("zero", 32'(zero), 32'(e[32]));
         check("overflow", 32'(overflow), 32'(e[33]));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", result, e[31:0]);
            check("hold_zero", 32'(zero), 32'(e[32]));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
         end
      end
      check("done_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("retire_out_valid", 32'(out_valid), 32'd0);
      check("retire_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ops [6];
      ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'h0;
      b         = 32'h0;
      op        = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", result, 32'h0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // out_ready with nothing pending must not produce a result
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_out_ready", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      issue(32'haaaaaaaa, 32'hbbbbbbbb, 3'b001); collect(0);
      issue(32'habcabcab, 32'h0000ffff, 3'b000); collect(0);
      issue(32'h7fffffff, 32'h00000001, 3'b010); collect(0);
      issue(32'h00000005, 32'h00000005, 3'b110); collect(0);
      issue(32'h80000000, 32'h00000001, 3'b110); collect(0);
      issue(32'hffffffff, 32'h00000001, 3'b111); collect(0);
      issue(32'h00000001, 32'hffffffff, 3'b111); collect(0);
      issue(32'h12345678, 32'h9abcdef0, 3'b011); collect(0);
      issue(32'h00000001, 32'd31,       3'b100); collect(0);
      issue(32'h80000000, 32'd4,        3'b101); collect(0);
      issue(32'h00001234, 32'd32,       3'b100); collect(0);
      issue(32'hf0f0f0f0, 32'd1,        3'b101); collect(0);

      // Backpressure
      issue(32'h00ff0000, 32'h000000ff, 3'b001); collect(10);

      for (int i = 0; i < 10; i++) begin
         issue($urandom, $urandom, ops[$urandom_range(0, 5)]);
         collect($urandom_range(0, 2));
      end
      for (int i = 0; i < 4; i++) begin
         issue($urandom, 32'($urandom_range(0, 31)), $urandom_range(0, 1) ? 3'b100 : 3'b101);
         collect(0);
      end

      // Reset in the middle of a long shift
      issue(32'h00000001, 32'd20, 3'b100);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_result", result, 32'h0);
      check("midrst_zero", 32'(zero), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_state", 32'(o_dbg_state), 32'd0);
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      issue(32'h00000001, 32'h00000000, 3'b001); collect(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu32_stage.md
# alu32_stage

Registered, handshaked 32-bit ALU stage that consumes the combinational bitwise/arithmetic units (or32, and32, adder) and presents one latched result per operation to the downstream writeback logic. Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in one cycle. Shifts (SLL, SRL) iterate one bit per cycle. Operands enter and results leave over valid/ready handshakes.

## Interface
- WIDTH, 32: datapath width; power of two; shift amount is b[log2(WIDTH)-1:0]
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept; equals (state==IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount source
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL, 101 SRL, 011 reserved
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, op.
  - Non-shift op: compute and register result/flags → DONE.
  - Shift op with shamt==0: result=a → DONE.
  - Shift op with shamt>0: acc=a, cnt=shamt → SHIFT.
- SHIFT: each cycle, shift acc by 1 (SLL: left, zero fill; SRL: logical right, zero fill) and decrement cnt. On the cycle cnt==1, shift and go to DONE.
- DONE: out_valid=1. result, zero and overflow stay stable until out_ready. On out_valid&&out_ready → IDLE.
- Arithmetic rules:
  - ADD/SUB are WIDTH-bit modulo.
  - ADD overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - SUB overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]).
  - SLT is a signed compare: result = {WIDTH-1 zeros, a<b}.
  - Reserved op 011: result=0, zero=1, overflow=0, latency 1.
- zero is registered with result and reflects the registered value.
- Inputs are ignored outside IDLE and while rst_n is low.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, result=0, zero=0, overflow=0, out_valid=0, internal cnt/acc=0. in_ready reads 1 once rst_n is high.
- Latency is measured from the accepting edge:
  - Non-shift op, or shift with shamt 0: out_valid high after 1 edge.
  - Shift with shamt=N>0: out_valid high after N+1 edges.
- Throughput: at most one op per 2 cycles. in_ready is 0 in SHIFT and DONE, including the cycle where out_ready completes the handshake; in_ready returns the next cycle.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- out_ready while out_valid is low has no effect.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values. No partial result is emitted after rst_n rises.
- in_valid high in the same cycle rst_n deasserts: that operand is accepted on the first rising edge with rst_n high.

## Test plan
- OR: a=0xaaaaaaaa, b=0xbbbbbbbb, op=001 → result=0xbbbbbbbb, zero=0, overflow=0, out_valid 1 cycle after accept. AND: a=0xabcabcab, b=0x0000ffff, op=000 → 0x0000bcab.
- ADD overflow: a=0x7fffffff, b=1, op=010 → 0x80000000, overflow=1. SUB zero: a=5, b=5, op=110 → 0, zero=1, overflow=0. SUB overflow: a=0x80000000, b=1 → 0x7fffffff, overflow=1.
- SLT: a=0xffffffff, b=1 → result=1. Swapped operands → result=0, zero=1.
- Shifts:
  - SLL: a=1, b=31 → 0x80000000, out_valid exactly 32 edges after accept.
  - SRL: a=0x80000000, b=4 → 0x08000000 after 5 edges.
  - SLL: a=0x1234, b=32 (shamt 0) → 0x1234 after 1 edge.
- Backpressure: complete an OR with out_ready held low for 10 cycles.
  - result, zero and out_valid stay stable and in_ready stays 0 throughout.
  - Raise out_ready: out_valid drops next edge; in_ready is 1 the cycle after.
- Reset: assert rst_n low 3 cycles into SLL a=1, b=20.
  - All outputs go to 0 immediately and in_ready is 1 after release.
  - A new OR of a=1, b=0 then returns result=1 with no stale shift result.
